// File: rtl/match_max_pkg.sv
// Shared types and default dimensions for the match-vector max unit.
package match_max_pkg;

  localparam int unsigned CAM_LEN_DEF    = 32'd32;
  localparam int unsigned GROUP_LEN_DEF  = 32'd16;
  localparam int unsigned NUM_GROUPS_DEF = 32'd16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_REDUCE  = 3'd2,
    ST_REPLAY  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Counter width for a count of n items; a single-item count still gets one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/match_max_if.sv
// Input and output valid/ready streams of the match-vector max unit.
interface match_max_if #(
  parameter int unsigned CAM_LEN = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [CAM_LEN-1:0] in_vector;
  logic               out_valid;
  logic               out_ready;
  logic [CAM_LEN-1:0] out_vector;

  modport master (
    output in_valid, in_vector, out_ready,
    input  in_ready, out_valid, out_vector
  );

  modport slave (
    input  in_valid, in_vector, out_ready,
    output in_ready, out_valid, out_vector
  );
endinterface

// File: rtl/match_max_find.sv
// Combinational isolator: keeps only the highest set bit of vec_i (zero in, zero out).
module match_max_find #(
  parameter int unsigned CAM_LEN = 32
) (
  input  logic [CAM_LEN-1:0] vec_i,
  output logic [CAM_LEN-1:0] onehot_o
);

  logic seen_s;

  // Walk from the MSB down; a bit survives only if nothing above it was set.
  always_comb begin
    onehot_o = '0;
    seen_s   = 1'b0;
    for (int i = int'(CAM_LEN) - 1; i >= 0; i--) begin
      onehot_o[i] = vec_i[i] & ~seen_s;
      seen_s      = seen_s | vec_i[i];
    end
  end

endmodule

// File: rtl/match_max_unit.sv
// Collects groups of match vectors, reduces each to a one-hot local max and replays
// them OR'd with it. Define MATCH_MAX_GLOBAL_EN to build the per-pass global_max register.
module match_max_unit
  import match_max_pkg::*;
#(
  parameter int unsigned CAM_LEN    = CAM_LEN_DEF,
  parameter int unsigned GROUP_LEN  = GROUP_LEN_DEF,
  parameter int unsigned NUM_GROUPS = NUM_GROUPS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  match_max_if.slave         bus,
  output logic [CAM_LEN-1:0] local_max,
  output logic [CAM_LEN-1:0] global_max,
  output logic               pass_done
);

  localparam int unsigned IDX_W = cnt_width(GROUP_LEN);
  localparam int unsigned GRP_W = cnt_width(NUM_GROUPS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(GROUP_LEN - 32'd1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_GROUPS - 32'd1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic [CAM_LEN-1:0] acc_q, acc_d;
  logic [CAM_LEN-1:0] lmax_q, lmax_d;
  logic [CAM_LEN-1:0] buf_q [GROUP_LEN];
  logic               buf_we_s;
  logic [CAM_LEN-1:0] peak_s;

  match_max_find #(.CAM_LEN(CAM_LEN)) u_find (
    .vec_i    (acc_q),
    .onehot_o (peak_s)
  );

  // Next-state and datapath control; abort overrides every transition.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    grp_d    = grp_q;
    acc_d    = acc_q;
    lmax_d   = lmax_q;
    buf_we_s = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      grp_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_COLLECT;
            idx_d   = '0;
            grp_d   = '0;
            acc_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_COLLECT: begin
          if (bus.in_valid) begin
            buf_we_s = 1'b1;
            acc_d    = acc_q | bus.in_vector;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              state_d = ST_REDUCE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            state_d = ST_COLLECT;
          end
        end
        ST_REDUCE: begin
          lmax_d  = peak_s;
          acc_d   = '0;
          state_d = ST_REPLAY;
        end
        ST_REPLAY: begin
          if (bus.out_ready) begin
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              if (grp_q == GRP_LAST) begin
                grp_d   = '0;
                state_d = ST_DONE;
              end else begin
                grp_d   = grp_q + GRP_W'(1);
                state_d = ST_COLLECT;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            state_d = ST_REPLAY;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control state, counters, accumulator and local max.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      grp_q   <= '0;
      acc_q   <= '0;
      lmax_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      grp_q   <= grp_d;
      acc_q   <= acc_d;
      lmax_q  <= lmax_d;
    end
  end

  // Group buffer; cleared on reset so nothing stale survives a mid-pass reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(GROUP_LEN); i++) begin
        buf_q[i] <= '0;
      end
    end else if (buf_we_s) begin
      buf_q[idx_q] <= bus.in_vector;
    end
  end

`ifdef MATCH_MAX_GLOBAL_EN
  logic [CAM_LEN-1:0] gmax_q, gmax_d;

  // Global max: cleared by an accepted start, accumulates each reduction, kept on abort.
  always_comb begin
    gmax_d = gmax_q;
    if (abort) begin
      gmax_d = gmax_q;
    end else if ((state_q == ST_IDLE) && start) begin
      gmax_d = '0;
    end else if (state_q == ST_REDUCE) begin
      gmax_d = gmax_q | peak_s;
    end else begin
      gmax_d = gmax_q;
    end
  end

  // Global max register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gmax_q <= '0;
    end else begin
      gmax_q <= gmax_d;
    end
  end

  assign global_max = gmax_q;
`else
  assign global_max = '0;
`endif

  assign local_max      = lmax_q;
  assign pass_done      = (state_q == ST_DONE);
  assign bus.in_ready   = (state_q == ST_COLLECT);
  assign bus.out_valid  = (state_q == ST_REPLAY);
  assign bus.out_vector = (state_q == ST_REPLAY) ? (buf_q[idx_q] | lmax_q) : '0;

endmodule

// File: tb/tb_match_max_unit.sv
// Directed and randomized checks of match_max_unit against a group-level reference model.
module tb_match_max_unit;

  localparam int unsigned CW = 8;
  localparam int unsigned GL = 4;
  localparam int unsigned NG = 2;

  typedef logic [CW-1:0] grp_t [GL];

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [CW-1:0] local_max;
  logic [CW-1:0] global_max;
  logic pass_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CW-1:0] gmax_m = 8'h00;
  logic [CW-1:0] lmax_m = 8'h00;

  match_max_if #(.CAM_LEN(CW)) bus ();

  match_max_unit #(.CAM_LEN(CW), .GROUP_LEN(GL), .NUM_GROUPS(NG)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .bus        (bus),
    .local_max  (local_max),
    .global_max (global_max),
    .pass_done  (pass_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic logic [CW-1:0] top_bit(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = 8'h00;
    for (int b = 0; b < int'(CW); b++) begin
      if (v[b]) r = 8'h01 << b;
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] group_max(input grp_t g);
    logic [CW-1:0] o;
    o = 8'h00;
    for (int k = 0; k < int'(GL); k++) o = o | g[k];
    return top_bit(o);
  endfunction

  function automatic logic [CW-1:0] exp_gmax();
`ifdef MATCH_MAX_GLOBAL_EN
    return gmax_m;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [CW-1:0] rand_vec();
    logic [CW-1:0] v;
    v = 8'($urandom & 32'hff);
    if ($urandom_range(0, 3) == 0) v = 8'h00;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    gmax_m = 8'h00;
    check("start_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic send_vec(input logic [CW-1:0] v, input int gap, input bit poke_start);
    int g;
    for (int s = 0; s < gap; s++) begin
      bus.in_valid = 1'b0;
      start = poke_start;
      step();
    end
    start = 1'b0;
    g = 0;
    while (!bus.in_ready && g < 20) begin
      step();
      g++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_vector = v;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_group(input grp_t g, input bit rnd);
    for (int k = 0; k < int'(GL); k++) begin
      send_vec(g[k], rnd ? int'($urandom_range(0, 2)) : 0, rnd ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  task automatic recv_group(input grp_t g, input int stall_idx, input int stall_len,
                            input bit rnd, input bit last);
    logic [CW-1:0] lm;
    int ns;
    int w;
    lm = group_max(g);
    lmax_m = lm;
    gmax_m = gmax_m | lm;
    for (int k = 0; k < int'(GL); k++) begin
      w = 0;
      while (!bus.out_valid && w < 20) begin
        step();
        w++;
      end
      check("out_valid_wait", 32'(bus.out_valid), 32'd1);
      check("replay_data", 32'(bus.out_vector), 32'(g[k] | lm));
      ns = (k == stall_idx) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < ns; s++) begin
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_vector = 8'($urandom & 32'hff);
        step();
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_hold", 32'(bus.out_vector), 32'(g[k] | lm));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
    check("local_max", 32'(local_max), 32'(lm));
    check("global_max", 32'(global_max), 32'(exp_gmax()));
    check("after_group_done", 32'(pass_done), 32'(last));
    check("after_group_ready", 32'(bus.in_ready), 32'(!last));
    if (last) begin
      step();
      check("pass_done_once", 32'(pass_done), 32'd0);
      check("idle_no_valid", 32'(bus.out_valid), 32'd0);
    end else begin
      check("mid_pass_no_done", 32'(pass_done), 32'd0);
    end
  endtask

  initial begin
    grp_t g0;
    grp_t g1;
    bus.in_valid  = 1'b0;
    bus.in_vector = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_vector", 32'(bus.out_vector), 32'd0);
    check("rst_pass_done", 32'(pass_done), 32'd0);
    check("rst_local_max", 32'(local_max), 32'd0);
    check("rst_global_max", 32'(global_max), 32'd0);
    #2 reset = 1'b1;
    step();
    check("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Directed pass: group0 with a long replay stall and latency check, group1 all zero
    g0 = '{8'h01, 8'h04, 8'h10, 8'h02};
    g1 = '{8'h00, 8'h00, 8'h00, 8'h00};
    do_start();
    send_group(g0, 1'b0);
    check("lat_t1_valid", 32'(bus.out_valid), 32'd0);
    check("lat_t1_ready", 32'(bus.in_ready), 32'd0);
    step();
    check("lat_t2_valid", 32'(bus.out_valid), 32'd1);
    recv_group(g0, 1, 5, 1'b0, 1'b0);
    check("dir_local_max", 32'(local_max), 32'h10);
    send_group(g1, 1'b0);
    recv_group(g1, -1, 0, 1'b0, 1'b1);
    check("dir_lmax_zero", 32'(local_max), 32'h00);
    check("dir_gmax_hold", 32'(global_max), 32'(exp_gmax()));
    step();
    check("gmax_held_idle", 32'(global_max), 32'(exp_gmax()));

    // Randomized passes with gaps, stalls, ignored starts and unconsumed offers
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < int'(GL); k++) begin
        g0[k] = rand_vec();
        g1[k] = rand_vec();
      end
      do_start();
      send_group(g0, 1'b1);
      recv_group(g0, -1, 0, 1'b1, 1'b0);
      send_group(g1, 1'b1);
      recv_group(g1, -1, 0, 1'b1, 1'b1);
    end

    // Abort on the third accept of group0, then restart from index 0
    g0 = '{8'h80, 8'h40, 8'h20, 8'h01};
    do_start();
    send_vec(8'h80, 0, 1'b0);
    send_vec(8'h40, 0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.in_vector = 8'hff;
    abort = 1'b1;
    step();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_lmax_kept", 32'(local_max), 32'(lmax_m));
    check("abort_gmax_kept", 32'(global_max), 32'(exp_gmax()));
    step();
    check("abort_stays_idle", 32'(bus.in_ready), 32'd0);
    g0 = '{8'h03, 8'h00, 8'h05, 8'h00};
    g1 = '{8'h00, 8'h00, 8'h00, 8'h02};
    do_start();
    send_group(g0, 1'b0);
    recv_group(g0, -1, 0, 1'b0, 1'b0);
    send_group(g1, 1'b0);
    recv_group(g1, -1, 0, 1'b0, 1'b1);

    // Asynchronous reset during replay, then a clean pass with no residue
    g0 = '{8'hf0, 8'h0f, 8'h81, 8'h7e};
    do_start();
    send_group(g0, 1'b0);
    step();
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_vector", 32'(bus.out_vector), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd0);
    check("arst_local_max", 32'(local_max), 32'd0);
    check("arst_global_max", 32'(global_max), 32'd0);
    check("arst_pass_done", 32'(pass_done), 32'd0);
    gmax_m = 8'h00;
    lmax_m = 8'h00;
    step();
    #2 reset = 1'b1;
    step();
    g0 = '{8'h00, 8'h00, 8'h00, 8'h08};
    g1 = '{8'h00, 8'h01, 8'h00, 8'h00};
    do_start();
    send_group(g0, 1'b0);
    recv_group(g0, 0, 2, 1'b0, 1'b0);
    send_group(g1, 1'b0);
    recv_group(g1, -1, 0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/match_max_unit.md
MATCH_MAX_UNIT -- requirements
Module: match_max_unit

Interface
REQ-001 Parameter CAM_LEN, default 32: match-vector width in bits, minimum 2.
REQ-002 Parameter GROUP_LEN, default 16: vectors per group, minimum 1.
REQ-003 Parameter NUM_GROUPS, default 16: groups per pass, minimum 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; the block is in reset while the port is 0.
REQ-006 start  input  1  one-cycle pulse that begins a pass.
REQ-007 abort  input  1  synchronous return to IDLE.
REQ-008 in_valid  input  1  in_vector is valid.
REQ-009 in_ready  output  1  block accepts in_vector.
REQ-010 in_vector  input  CAM_LEN  incoming match vector.
REQ-011 out_valid  output  1  out_vector is valid.
REQ-012 out_ready  input  1  consumer accepts out_vector.
REQ-013 out_vector  output  CAM_LEN  stored vector OR'd with its group's local max.
REQ-014 local_max  output  CAM_LEN  one-hot local max of the most recently reduced group.
REQ-015 global_max  output  CAM_LEN  OR of all local maxes in the current pass.
REQ-016 pass_done  output  1  one-cycle pulse at the end of a pass.

Function
REQ-017 FSM states SHALL be IDLE, COLLECT, REDUCE, REPLAY and DONE.
REQ-018 IDLE: start=1 -> COLLECT; group counter, OR accumulator and global_max cleared; start is ignored in all other states.
REQ-019 COLLECT: in_ready=1; each in_valid&&in_ready handshake writes in_vector into buffer[idx] and ORs it into the accumulator; the GROUP_LEN-th handshake -> REDUCE.
REQ-020 REDUCE (exactly one cycle): local_max <= highest set bit of the accumulator, isolated to one-hot (all zero if the accumulator is zero); global_max |= that value; accumulator cleared; -> REPLAY.
REQ-021 REPLAY: out_valid=1, out_vector = buffer[ridx] | local_max; ridx advances on out_ready; out_vector is held stable while out_ready=0.
REQ-022 After the GROUP_LEN-th replay handshake: -> COLLECT with group+1, or -> DONE when group = NUM_GROUPS-1.
REQ-023 DONE: pass_done=1 for exactly one cycle, then -> IDLE; global_max holds until the next start.
REQ-024 Latency: final group accept at cycle t -> REDUCE at t+1 -> first out_valid at t+2.
REQ-025 in_ready=0 outside COLLECT and out_valid=0 outside REPLAY; an input offered while in_ready=0 is not consumed.
REQ-026 Counters SHALL be $clog2(max(N,2)) bits wide and wrap to 0 at the end of each group or pass, never at a power-of-two boundary.
REQ-027 abort takes priority over every transition: -> IDLE next cycle; counters and accumulator cleared; local_max and global_max retained.
REQ-028 GROUP_LEN=1: each group performs one accept, one REDUCE and one replay.

Reset
REQ-029 While reset=0: state=IDLE; all counters, the accumulator, the buffer, local_max and global_max are 0; in_ready, out_valid, pass_done and out_vector are 0.
REQ-030 Reset asserted mid-pass aborts immediately, and no stale buffered vector may appear after release.

Configuration
REQ-031 Macro MATCH_MAX_GLOBAL_EN: when defined, the global_max register and its update in REQ-020 are compiled in.
REQ-032 When MATCH_MAX_GLOBAL_EN is undefined, global_max is tied to 0 and no register is built for it; all other behaviour is identical.

Structure
REQ-033 Package match_max_pkg SHALL hold the FSM state enum and the default CAM_LEN, GROUP_LEN and NUM_GROUPS constants.
REQ-034 Sub-module match_max_find SHALL be a purely combinational, CAM_LEN-parametrised highest-set-bit one-hot isolator, instantiated once.

Verification
REQ-035 CAM_LEN=8, GROUP_LEN=4, NUM_GROUPS=2; group0 = 0x01,0x04,0x10,0x02 -> local_max=0x10; replay 0x11,0x14,0x10,0x12.
REQ-036 Group1 = all 0x00 -> local_max=0x00; replay four 0x00; pass_done pulses once; global_max=0x10.
REQ-037 out_ready held low for 5 cycles during replay -> out_vector stable, no index skipped; out_valid first seen 2 cycles after the final accept.
REQ-038 abort asserted on the 3rd accept of group0 -> IDLE next cycle, in_ready=0; a new start resumes at buffer index 0.
REQ-039 reset=0 pulsed during REPLAY -> all outputs 0 asynchronously; after release, start plus a new group gives correct results with no residue.
REQ-040 Build without MATCH_MAX_GLOBAL_EN, rerun REQ-035 -> identical out_vector stream; global_max constant 0.
